flexka_operand_merging_gen: RTL and testbench

- Generalised operand-merging engine for the Karatsuba datapath.
- Streams two multi-word operands L and H out of a two-read-port buffer RAM and computes H+L (ADD) or H−L (SUB), word-serially with carry/borrow propagation.
- Writes the result back through the RAM write port at a destination base.
- Differences from the fixed-function merger:
  - independent operand bases and lengths;
  - runtime add/subtract mode;
  - parametrised word width and RAM read latency;
  - busy/done handshake with start-while-busy protection;
  - borrow reporting.

---
 rtl/flexka_operand_merging_gen.sv | 233 +++++++++++++++++++++++
 tb/tb_flexka_operand_merging_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flexka_operand_merging_gen.sv
// Word-serial Karatsuba operand merger: streams L and H from a dual-read RAM,
// computes H+L or H-L with carry/borrow chaining and writes the result back at dst.
module flexka_operand_merging_gen #(
  parameter int unsigned WSIZE  = 64,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_l,
  input  logic [LEN_W-1:0]  len_l,
  input  logic [ADDR_W-1:0] base_h,
  input  logic [LEN_W-1:0]  len_h,
  input  logic [ADDR_W-1:0] dst,
  output logic              busy,
  output logic              done,
  output logic [LEN_W:0]    res_len,
  output logic              borrow,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] raddr0,
  output logic [ADDR_W-1:0] raddr1,
  input  logic [WSIZE-1:0]  rdata0,
  input  logic [WSIZE-1:0]  rdata1,
  output logic              wren,
  output logic [ADDR_W-1:0] waddr,
  output logic [WSIZE-1:0]  wdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINAL} state_t;

  state_t              r_state, w_state;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic [LEN_W:0]      r_res_len, w_res_len;
  logic                r_borrow, w_borrow;
  logic [ADDR_W-1:0]   r_raddr0, w_raddr0;
  logic [ADDR_W-1:0]   r_raddr1, w_raddr1;
  logic                r_wren, w_wren;
  logic [ADDR_W-1:0]   r_waddr, w_waddr;
  logic [WSIZE-1:0]    r_wdata, w_wdata;
  logic                r_wr_last, w_wr_last;
  logic                r_mode, w_mode;
  logic [LEN_W-1:0]    r_len_l, w_len_l;
  logic [LEN_W-1:0]    r_len_h, w_len_h;
  logic [LEN_W-1:0]    r_n, w_n;
  logic [LEN_W-1:0]    r_idx, w_idx;
  logic [ADDR_W-1:0]   r_wptr, w_wptr;
  logic                r_cy, w_cy;

  // Read-request delay line; index 0 is the issue stage, index RD_LAT lines up with returned data.
  logic [RD_LAT:0]     r_p_vld, r_p_zl, r_p_zh, r_p_last;
  logic                w_p0_vld, w_p0_zl, w_p0_zh, w_p0_last;

  logic [LEN_W-1:0]    w_n_in;
  logic [LEN_W-1:0]    w_idx_inc;
  logic [WSIZE-1:0]    w_l, w_h;
  logic [WSIZE:0]      w_sum, w_dif, w_res;

  assign w_n_in    = (len_l > len_h) ? len_l : len_h;
  assign w_idx_inc = r_idx + LEN_W'(1);

  // Operand words past the end of a shorter operand read as zero.
  assign w_l   = r_p_zl[RD_LAT] ? '0 : rdata0;
  assign w_h   = r_p_zh[RD_LAT] ? '0 : rdata1;
  assign w_sum = {1'b0, w_h} + {1'b0, w_l} + (WSIZE+1)'(r_cy);
  assign w_dif = {1'b0, w_h} - {1'b0, w_l} - (WSIZE+1)'(r_cy);
  assign w_res = r_mode ? w_dif : w_sum;

  always_comb begin
    w_state   = r_state;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_res_len = r_res_len;
    w_borrow  = r_borrow;
    w_raddr0  = r_raddr0;
    w_raddr1  = r_raddr1;
    w_wren    = 1'b0;
    w_waddr   = r_waddr;
    w_wdata   = r_wdata;
    w_wr_last = 1'b0;
    w_mode    = r_mode;
    w_len_l   = r_len_l;
    w_len_h   = r_len_h;
    w_n       = r_n;
    w_idx     = r_idx;
    w_wptr    = r_wptr;
    w_cy      = r_cy;
    w_p0_vld  = 1'b0;
    w_p0_zl   = 1'b0;
    w_p0_zh   = 1'b0;
    w_p0_last = 1'b0;

    if (r_p_vld[RD_LAT]) begin
      w_wren    = 1'b1;
      w_waddr   = r_wptr;
      w_wdata   = w_res[WSIZE-1:0];
      w_cy      = w_res[WSIZE];
      w_wptr    = r_wptr + ADDR_W'(1);
      w_wr_last = r_p_last[RD_LAT];
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mode  = mode;
          w_len_l = len_l;
          w_len_h = len_h;
          w_n     = w_n_in;
          w_wptr  = dst;
          w_cy    = 1'b0;
          w_idx   = '0;
          if (w_n_in != '0) begin
            w_state   = S_ISSUE;
            w_busy    = 1'b1;
            w_raddr0  = base_l;
            w_raddr1  = base_h;
            w_p0_vld  = 1'b1;
            w_p0_zl   = (len_l == '0);
            w_p0_zh   = (len_h == '0);
            w_p0_last = (w_n_in == LEN_W'(1));
          end else begin
            w_state   = S_FINAL;
            w_busy    = 1'b0;
            w_done    = 1'b1;
            w_res_len = '0;
            w_borrow  = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        if (r_idx == r_n - LEN_W'(1)) begin
          w_state = S_DRAIN;
        end else begin
          w_idx     = w_idx_inc;
          w_raddr0  = r_raddr0 + ADDR_W'(1);
          w_raddr1  = r_raddr1 + ADDR_W'(1);
          w_p0_vld  = 1'b1;
          w_p0_zl   = (w_idx_inc >= r_len_l);
          w_p0_zh   = (w_idx_inc >= r_len_h);
          w_p0_last = (w_idx_inc == r_n - LEN_W'(1));
        end
      end
      S_DRAIN: begin
        // Last word is on the write port this cycle, so r_cy holds the final carry/borrow.
        if (r_wr_last) begin
          w_state  = S_FINAL;
          w_busy   = 1'b0;
          w_done   = 1'b1;
          w_borrow = r_mode & r_cy;
          if (!r_mode && r_cy) begin
            w_wren    = 1'b1;
            w_waddr   = r_wptr;
            w_wdata   = WSIZE'(1);
            w_res_len = {1'b0, r_n} + (LEN_W+1)'(1);
          end else begin
            w_res_len = {1'b0, r_n};
          end
        end
      end
      S_FINAL: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_res_len <= '0;
      r_borrow  <= 1'b0;
      r_raddr0  <= '0;
      r_raddr1  <= '0;
      r_wren    <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wr_last <= 1'b0;
      r_mode    <= 1'b0;
      r_len_l   <= '0;
      r_len_h   <= '0;
      r_n       <= '0;
      r_idx     <= '0;
      r_wptr    <= '0;
      r_cy      <= 1'b0;
      r_p_vld   <= '0;
      r_p_zl    <= '0;
      r_p_zh    <= '0;
      r_p_last  <= '0;
    end else begin
      r_state   <= w_state;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_res_len <= w_res_len;
      r_borrow  <= w_borrow;
      r_raddr0  <= w_raddr0;
      r_raddr1  <= w_raddr1;
      r_wren    <= w_wren;
      r_waddr   <= w_waddr;
      r_wdata   <= w_wdata;
      r_wr_last <= w_wr_last;
      r_mode    <= w_mode;
      r_len_l   <= w_len_l;
      r_len_h   <= w_len_h;
      r_n       <= w_n;
      r_idx     <= w_idx;
      r_wptr    <= w_wptr;
      r_cy      <= w_cy;
      r_p_vld   <= {r_p_vld[RD_LAT-1:0],  w_p0_vld};
      r_p_zl    <= {r_p_zl[RD_LAT-1:0],   w_p0_zl};
      r_p_zh    <= {r_p_zh[RD_LAT-1:0],   w_p0_zh};
      r_p_last  <= {r_p_last[RD_LAT-1:0], w_p0_last};
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign res_len  = r_res_len;
  assign borrow   = r_borrow;
  assign rd_valid = r_p_vld[0];
  assign raddr0   = r_raddr0;
  assign raddr1   = r_raddr1;
  assign wren     = r_wren;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;

endmodule

// File: tb/tb_flexka_operand_merging_gen.sv
// Directed bench for flexka_operand_merging_gen: three instances at RD_LAT 2/1/4
// sharing one read-only RAM image; writes are captured into omem as they appear.
module tb_flexka_operand_merging_gen;

  localparam int unsigned WS = 64;
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 10;
  localparam logic [WS-1:0] ONES = {WS{1'b1}};
  localparam logic [WS-1:0] SENT = 64'hA5A5_A5A5_A5A5_A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          mode;
  logic [AW-1:0] base_l, base_h, dst;
  logic [LW-1:0] len_l, len_h;

  logic          start    [3];
  logic          busy     [3];
  logic          done     [3];
  logic          borrow   [3];
  logic          rd_valid [3];
  logic          wren     [3];
  logic [LW:0]   res_len  [3];
  logic [AW-1:0] raddr0   [3];
  logic [AW-1:0] raddr1   [3];
  logic [AW-1:0] waddr    [3];
  logic [WS-1:0] wdata    [3];
  logic [WS-1:0] rdata0   [3];
  logic [WS-1:0] rdata1   [3];

  logic [WS-1:0] rmem [1024];
  logic [WS-1:0] omem [1024];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [WS-1:0] ql [1:4];
    logic [WS-1:0] qh [1:4];

    always @(posedge clk) begin
      ql[1] <= rmem[raddr0[g]];
      qh[1] <= rmem[raddr1[g]];
      for (int k = 2; k <= 4; k++) begin
        ql[k] <= ql[k-1];
        qh[k] <= qh[k-1];
      end
    end

    assign rdata0[g] = ql[LT];
    assign rdata1[g] = qh[LT];

    flexka_operand_merging_gen #(
      .WSIZE(WS), .ADDR_W(AW), .LEN_W(LW), .RD_LAT(LT)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .mode(mode),
      .base_l(base_l), .len_l(len_l), .base_h(base_h), .len_h(len_h), .dst(dst),
      .busy(busy[g]), .done(done[g]), .res_len(res_len[g]), .borrow(borrow[g]),
      .rd_valid(rd_valid[g]), .raddr0(raddr0[g]), .raddr1(raddr1[g]),
      .rdata0(rdata0[g]), .rdata1(rdata1[g]),
      .wren(wren[g]), .waddr(waddr[g]), .wdata(wdata[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic m, input int bl, input int ll, input int bh, input int lh,
                       input int d);
    mode   = m;
    base_l = AW'(bl);
    len_l  = LW'(ll);
    base_h = AW'(bh);
    len_h  = LW'(lh);
    dst    = AW'(d);
  endtask

  // Starts instance w in the next cycle and follows it to done; poke>0 re-pulses start then.
  task automatic run(input int w, input string tag, input int poke, input int e_cyc,
                     input int e_len, input logic e_b, input int e_nw);
    int cyc;
    int nw;
    bit seen;
    @(negedge clk);
    start[w] = 1'b1;
    cyc  = 0;
    nw   = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start[w] = 1'b0;
      if (cyc == 1) begin
        check({tag, "_busy1"}, 64'(busy[w]), 64'd1);
        check({tag, "_issue0"}, 64'({rd_valid[w], raddr0[w], raddr1[w]}),
              64'({1'b1, base_l, base_h}));
      end
      if (wren[w]) begin
        omem[waddr[w]] = wdata[w];
        nw++;
      end
      if (done[w]) begin
        seen = 1'b1;
        check({tag, "_cyc"}, 64'(cyc), 64'(e_cyc));
        check({tag, "_len_brw"}, 64'({res_len[w], borrow[w]}), 64'({11'(e_len), e_b}));
        check({tag, "_busy_done"}, 64'(busy[w]), 64'd0);
      end else if (cyc == poke) begin
        start[w] = 1'b1;
        dst      = 10'h3C0;
        len_h    = 10'd9;
      end
    end
    if (!seen) check({tag, "_timeout"}, 64'(cyc), 64'(e_cyc));
    check({tag, "_nwr"}, 64'(nw), 64'(e_nw));
  endtask

  initial begin
    int nw;
    for (int i = 0; i < 1024; i++) begin
      rmem[i] = '0;
      omem[i] = SENT;
    end
    for (int i = 0; i < 4; i++) begin
      rmem[10'h000 + i] = 64'd1;
      rmem[10'h010 + i] = 64'd1;
      rmem[10'h020 + i] = ONES;
    end
    rmem[10'h100] = ONES;
    rmem[10'h101] = ONES;
    rmem[10'h102] = 64'hDEAD_BEEF_0000_1234;
    rmem[10'h103] = 64'hDEAD_BEEF_0000_5678;
    rmem[10'h104] = 64'hDEAD_BEEF_0000_9ABC;
    rmem[10'h110] = 64'd1;
    rmem[10'h111] = 64'd0;
    rmem[10'h112] = 64'd5;
    rmem[10'h113] = 64'd6;
    rmem[10'h114] = 64'd7;
    rmem[10'h200] = 64'd1;
    rmem[10'h201] = 64'd0;
    rmem[10'h210] = 64'd0;
    rmem[10'h211] = 64'd1;

    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    rst = 1'b1;
    setup(1'b0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_ctl", 64'({busy[0], done[0], borrow[0], rd_valid[0], wren[0]}), 64'd0);
    check("rst_len", 64'(res_len[0]), 64'd0);
    check("rst_addr", 64'({raddr0[0], raddr1[0], waddr[0]}), 64'd0);
    check("rst_wdata", wdata[0], 64'd0);
    rst = 1'b0;

    // ADD of ones, then an immediate back-to-back repeat
    setup(1'b0, 'h000, 4, 'h010, 4, 'h300);
    run(0, "add1", 0, 8, 4, 1'b0, 4);
    setup(1'b0, 'h000, 4, 'h010, 4, 'h310);
    run(0, "b2b", 0, 8, 4, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("add1_w%0d", i), omem[10'h300 + i], 64'd2);
      check($sformatf("b2b_w%0d", i), omem[10'h310 + i], 64'd2);
    end
    check("add1_no_w4", omem[10'h304], SENT);

    // ADD of all-ones: carry ripples out into an extra word
    setup(1'b0, 'h020, 4, 'h020, 4, 'h320);
    run(0, "ones", 0, 8, 5, 1'b0, 5);
    check("ones_w0", omem[10'h320], {ONES[WS-1:1], 1'b0});
    check("ones_w123", omem[10'h321] & omem[10'h322] & omem[10'h323], ONES);
    check("ones_w4", omem[10'h324], 64'd1);

    // Unequal lengths, both orders
    setup(1'b0, 'h100, 2, 'h110, 5, 'h330);
    run(0, "l2h5", 0, 9, 5, 1'b0, 5);
    setup(1'b0, 'h110, 5, 'h100, 2, 'h340);
    run(0, "l5h2", 0, 9, 5, 1'b0, 5);
    check("l2h5_w01", {omem[10'h330], omem[10'h331]}, 64'd0);
    check("l2h5_w2", omem[10'h332], 64'd6);
    check("l2h5_w3", omem[10'h333], 64'd6);
    check("l2h5_w4", omem[10'h334], 64'd7);
    check("l5h2_w01", {omem[10'h340], omem[10'h341]}, 64'd0);
    check("l5h2_w234", {omem[10'h342][7:0], omem[10'h343][7:0], omem[10'h344][7:0]},
          64'h060607);

    // SUB without and with final borrow
    setup(1'b1, 'h200, 2, 'h210, 2, 'h350);
    run(0, "sub2", 0, 6, 2, 1'b0, 2);
    check("sub2_w0", omem[10'h350], ONES);
    check("sub2_w1", omem[10'h351], 64'd0);
    setup(1'b1, 'h200, 1, 'h210, 1, 'h360);
    run(0, "sub1", 0, 5, 1, 1'b1, 1);
    check("sub1_w0", omem[10'h360], ONES);

    // start while busy is ignored
    setup(1'b0, 'h000, 4, 'h010, 4, 'h370);
    run(0, "poke", 3, 8, 4, 1'b0, 4);
    check("poke_w3", omem[10'h373], 64'd2);
    check("poke_alt", omem[10'h3C0], SENT);

    // Reset during ISSUE
    setup(1'b0, 'h000, 4, 'h010, 4, 'h380);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_idle", 64'({busy[0], rd_valid[0], wren[0], done[0]}), 64'd0);
    rst = 1'b0;
    nw = 0;
    repeat (12) begin
      @(negedge clk);
      if (wren[0] || done[0]) nw++;
    end
    check("rstmid_quiet", 64'(nw), 64'd0);

    // Other read latencies
    setup(1'b0, 'h000, 4, 'h010, 4, 'h390);
    run(1, "lat1", 0, 7, 4, 1'b0, 4);
    setup(1'b0, 'h000, 4, 'h010, 4, 'h3A0);
    run(2, "lat4", 0, 10, 4, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lat1_w%0d", i), omem[10'h390 + i], 64'd2);
      check($sformatf("lat4_w%0d", i), omem[10'h3A0 + i], 64'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
